key_dispatch_sched: RTL and testbench
=====================================

Name: key_dispatch_sched

Overview:
- Scheduler that shares one RC4 secret-key search across NUM_CORES identical cracking cores. Each core runs init/swap/decode for a single key.
- Hands out consecutive candidate keys from LOW_KEY up to HIGH_KEY-1, tracks which cores are busy, and stops the search on the first reported match.
- Drives the pass/fail LEDs and the found-key display.
- Sits above the per-core master FSMs, replacing their local key increment.

Parameters:
- NUM_CORES, 4, number of cracking cores (1..8)
- KEY_W, 24, secret key width
- LOW_KEY, 24'h000000, first key dispatched
- HIGH_KEY, 24'h400000, exclusive upper bound; key HIGH_KEY is never dispatched

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  1-cycle pulse; begins search when IDLE
- core_done  in  NUM_CORES  per-core 1-cycle pulse: current key finished
- core_found  in  NUM_CORES  valid only with core_done; 1 = key decrypted to all-printable text
- core_start  out  NUM_CORES  per-core 1-cycle pulse: begin key on core_key slice
- core_key  out  NUM_CORES*KEY_W  per-core key; slice i = bits [i*KEY_W +: KEY_W]
- core_halt  out  1  level; cores abandon work and return to idle
- busy  out  1  search in progress
- pass  out  1  level; key found
- fail  out  1  level; range exhausted without a match
- found_key  out  KEY_W  matching key; valid while pass
- found_core  out  3  index of the core that found the key
- keys_tried  out  KEY_W  completed-key count (optional feature)

Behaviour:
- Reset (synchronous): state IDLE, next_key=LOW_KEY, busy_vec=0. All outputs 0, except core_key slices, which reset to LOW_KEY.
- States: IDLE, RUN, PASS, FAIL.
- IDLE:
  - start=1 → RUN, next_key=LOW_KEY, busy_vec=0.
  - Any other input is ignored.
- RUN:
  - busy=1.
  - Each cycle, at most one dispatch.
  - Target: the lowest-index core whose registered busy_vec bit is 0, provided next_key<HIGH_KEY.
  - On dispatch: core_start[i]=1 for one cycle, core_key slice i=next_key (held until that core's next dispatch), busy_vec[i] set, next_key+1.
  - core_done[i] clears busy_vec[i] at the clock edge. The core becomes eligible one cycle later, so done and re-dispatch never occur in the same cycle for the same core.
  - core_done on a non-busy core is ignored.
- Match:
  - Any core_done[i]&core_found[i] → PASS next cycle.
  - found_key = core_key slice i; found_core = i.
  - If several cores report found in the same cycle, the lowest index wins.
  - No dispatch occurs in the match cycle.
- Exhaustion: next_key==HIGH_KEY and busy_vec==0 and no found this cycle → FAIL.
- PASS/FAIL: terminal until reset.
  - core_halt=1, busy=0.
  - pass or fail held at 1.
  - start ignored.
- Arithmetic: next_key is KEY_W+1 bits internally so HIGH_KEY=2^KEY_W does not wrap. Comparison is unsigned.
- LOW_KEY>=HIGH_KEY: RUN → FAIL on the first RUN cycle, with zero dispatches.
- Reset mid-RUN: immediate return to IDLE. Cores see core_halt=0 and no core_start. Cores must also be reset by the same reset.
- Latency:
  - start → first core_start: 1 cycle.
  - found done → pass: 1 cycle.

Optional Feature:
- Macro SCHED_PERF_CNT_EN.
- Defined: keys_tried counts core_done pulses on busy cores during RUN, saturating at all-ones. It clears on start and reset and freezes in PASS/FAIL.
- Undefined: keys_tried tied to 0; no counter logic.

Decomposition:
- Package key_sched_pkg:
  - state enum (IDLE, RUN, PASS, FAIL)
  - KEY_W default
  - MAX_CORES=8
  - core index type
- Sub-module core_pick_lsb: combinational lowest-set-bit finder with parameterized width, returning a valid flag and a 3-bit index. Used for the dispatch choice (on ~busy_vec) and for found arbitration.

Test Plan:
1. NUM_CORES=4, LOW=0, HIGH=16, cores finish 5 cycles after start, never found, start pulse:
   - keys 0..3 dispatched on cycles 1..4, one per cycle, to cores 0..3.
   - All 16 keys dispatched exactly once.
   - fail=1 after the last done; keys_tried=16 with macro.
2. Same setup, core 2 reports found on key 6:
   - pass=1 one cycle after that done; found_key=6, found_core=2.
   - core_halt=1; no core_start afterwards.
3. Cores 1 and 3 report found in the same cycle:
   - found_core=1, found_key = core 1's key.
4. core_done[0] pulse in the same cycle core 1 is dispatched:
   - core 0 is re-dispatched no earlier than the next cycle.
   - No key is skipped or duplicated (scoreboard over the range).
5. LOW=10, HIGH=10, start:
   - fail=1 with zero core_start pulses.
   - start while FAIL is ignored.
6. reset asserted mid-RUN after 7 dispatches, then start:
   - outputs return to reset values.
   - The new run redispatches from LOW_KEY.
   - keys_tried restarts at 0.

Source files
------------

// File: rtl/key_sched_pkg.sv
// Shared types for the RC4 key-search scheduler: FSM states, core index type, widths.
package key_sched_pkg;

  localparam int KEY_W_DEF  = 24;
  localparam int MAX_CORES  = 8;
  localparam int CORE_IDX_W = 3;

  typedef logic [CORE_IDX_W-1:0] core_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } sched_state_e;

  function automatic logic [3:0] popcnt8(input logic [MAX_CORES-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < MAX_CORES; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/core_pick_lsb.sv
// Combinational lowest-set-bit finder; o_vld=0 when no bit is set, o_idx then reads 0.
module core_pick_lsb
  import key_sched_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] i_vec,
  output logic         o_vld,
  output core_idx_t    o_idx
);

  always_comb begin
    o_vld = 1'b0;
    o_idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_vld = 1'b1;
        o_idx = core_idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/key_dispatch_sched.sv
// Hands consecutive RC4 keys to idle cracking cores, stops on first match or range end; 1-cycle start->core_start and found->pass.
// Optional completed-key counter on keys_tried is built when SCHED_PERF_CNT_EN is defined.
module key_dispatch_sched
  import key_sched_pkg::*;
#(
  parameter int               NUM_CORES = 4,
  parameter int               KEY_W     = KEY_W_DEF,
  parameter logic [KEY_W-1:0] LOW_KEY   = '0,
  parameter logic [KEY_W:0]   HIGH_KEY  = 'h400000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_CORES-1:0]       core_done,
  input  logic [NUM_CORES-1:0]       core_found,
  output logic [NUM_CORES-1:0]       core_start,
  output logic [NUM_CORES*KEY_W-1:0] core_key,
  output logic                       core_halt,
  output logic                       busy,
  output logic                       pass,
  output logic                       fail,
  output logic [KEY_W-1:0]           found_key,
  output logic [2:0]                 found_core,
  output logic [KEY_W-1:0]           keys_tried
);

  sched_state_e           r_state;
  logic [KEY_W:0]         r_next_key;
  logic [NUM_CORES-1:0]   r_busy_vec;
  logic [NUM_CORES-1:0]   r_core_start;
  logic [KEY_W-1:0]       r_core_key [NUM_CORES];
  logic [KEY_W-1:0]       r_found_key;
  core_idx_t              r_found_core;

  logic                   w_run;
  logic                   w_idle_go;
  logic [NUM_CORES-1:0]   w_done_vec;
  logic [NUM_CORES-1:0]   w_found_vec;
  logic [NUM_CORES-1:0]   w_cur_busy;
  logic [KEY_W:0]         w_cur_next;
  logic                   w_keys_left;
  logic                   w_free_vld;
  core_idx_t              w_free_idx;
  logic                   w_found_vld;
  core_idx_t              w_found_idx;
  logic                   w_disp;
  logic [NUM_CORES-1:0]   w_disp_vec;
  logic                   w_exhausted;
  logic [KEY_W-1:0]       w_found_key;

  assign w_run     = (r_state == ST_RUN);
  assign w_idle_go = (r_state == ST_IDLE) && start;

  // Done/found from a core that was never dispatched carries no key and is dropped.
  assign w_done_vec  = w_run ? (core_done & r_busy_vec) : '0;
  assign w_found_vec = w_done_vec & core_found;

  // The start cycle dispatches too, from a clean slate, so core 0 starts one cycle after start.
  assign w_cur_busy  = w_idle_go ? '0 : r_busy_vec;
  assign w_cur_next  = w_idle_go ? {1'b0, LOW_KEY} : r_next_key;
  assign w_keys_left = (w_cur_next < HIGH_KEY);

  core_pick_lsb #(.W(NUM_CORES)) u_pick_free (
    .i_vec (~w_cur_busy),
    .o_vld (w_free_vld),
    .o_idx (w_free_idx)
  );

  core_pick_lsb #(.W(NUM_CORES)) u_pick_found (
    .i_vec (w_found_vec),
    .o_vld (w_found_vld),
    .o_idx (w_found_idx)
  );

  assign w_disp = (w_idle_go || (w_run && !w_found_vld)) && w_free_vld && w_keys_left;

  always_comb begin
    w_disp_vec = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_disp_vec[i] = w_disp && (w_free_idx == core_idx_t'(i));
    end
  end

  assign w_exhausted = w_run && !w_keys_left && (r_busy_vec == '0) && !w_found_vld;

  always_comb begin
    w_found_key = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_found_idx == core_idx_t'(i)) begin
        w_found_key = r_core_key[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_next_key   <= {1'b0, LOW_KEY};
      r_busy_vec   <= '0;
      r_core_start <= '0;
      r_found_key  <= '0;
      r_found_core <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        r_core_key[i] <= LOW_KEY;
      end
    end else begin
      r_core_start <= w_disp_vec;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_disp_vec[i]) begin
          r_core_key[i] <= w_cur_next[KEY_W-1:0];
        end
      end
      if (w_disp) begin
        r_next_key <= w_cur_next + {{KEY_W{1'b0}}, 1'b1};
      end else if (w_idle_go) begin
        r_next_key <= {1'b0, LOW_KEY};
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_RUN;
            r_busy_vec <= w_disp_vec;
          end
        end
        ST_RUN: begin
          r_busy_vec <= (r_busy_vec & ~w_done_vec) | w_disp_vec;
          if (w_found_vld) begin
            r_state      <= ST_PASS;
            r_found_key  <= w_found_key;
            r_found_core <= w_found_idx;
          end else if (w_exhausted) begin
            r_state <= ST_FAIL;
          end
        end
        default: ;
      endcase
    end
  end

  genvar g;
  for (g = 0; g < NUM_CORES; g++) begin : g_key
    assign core_key[g*KEY_W +: KEY_W] = r_core_key[g];
  end

  assign core_start = r_core_start;
  assign busy       = (r_state == ST_RUN);
  assign pass       = (r_state == ST_PASS);
  assign fail       = (r_state == ST_FAIL);
  assign core_halt  = pass || fail;
  assign found_key  = r_found_key;
  assign found_core = r_found_core;

`ifdef SCHED_PERF_CNT_EN
  logic [KEY_W-1:0] r_keys_tried;
  logic [3:0]       w_done_cnt;
  logic [KEY_W:0]   w_kt_sum;

  assign w_done_cnt = popcnt8(MAX_CORES'(w_done_vec));
  assign w_kt_sum   = {1'b0, r_keys_tried} + (KEY_W+1)'(w_done_cnt);

  always_ff @(posedge clock) begin
    if (reset || w_idle_go) begin
      r_keys_tried <= '0;
    end else if (w_run) begin
      r_keys_tried <= w_kt_sum[KEY_W] ? '1 : w_kt_sum[KEY_W-1:0];
    end
  end

  assign keys_tried = r_keys_tried;
`else
  assign keys_tried = '0;
`endif

endmodule

// File: tb/tb_key_dispatch_sched.sv
// Directed bench: behavioural cores (fixed 5-cycle latency) plus hand-driven done/found pulses.
module tb_key_dispatch_sched;

  localparam int NC = 4;
  localparam int KW = 24;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic e_start = 1'b0;
  logic auto_en = 1'b0;
  logic match_en = 1'b0;
  logic sb_clr = 1'b0;
  logic [KW-1:0] match_key = '0;
  logic [NC-1:0] man_done = '0;
  logic [NC-1:0] man_found = '0;
  logic [NC-1:0] m_done = '0;
  logic [NC-1:0] m_found = '0;
  logic [NC-1:0] e_zero = '0;
  logic [NC-1:0] core_done, core_found;

  logic [NC-1:0]    core_start, e_core_start;
  logic [NC*KW-1:0] core_key, e_core_key;
  logic             core_halt, busy, pass, fail;
  logic             e_core_halt, e_busy, e_pass, e_fail;
  logic [KW-1:0]    found_key, keys_tried, e_found_key, e_keys_tried;
  logic [2:0]       found_core, e_found_core;

  int n_tests = 0;
  int n_fail = 0;
  int cnt [NC];
  logic [KW-1:0] cur_key [NC];
  int disp_cnt [16];
  int n_starts = 0;
  int e_starts = 0;
  int kidx;

  assign core_done  = (auto_en ? m_done : '0) | man_done;
  assign core_found = (auto_en ? m_found : '0) | man_found;

  always #5 clock = ~clock;

  key_dispatch_sched #(.NUM_CORES(NC), .KEY_W(KW), .LOW_KEY(24'd0), .HIGH_KEY(25'd16)) u_dut (
    .clock(clock), .reset(reset), .start(start),
    .core_done(core_done), .core_found(core_found),
    .core_start(core_start), .core_key(core_key), .core_halt(core_halt),
    .busy(busy), .pass(pass), .fail(fail),
    .found_key(found_key), .found_core(found_core), .keys_tried(keys_tried)
  );

  key_dispatch_sched #(.NUM_CORES(NC), .KEY_W(KW), .LOW_KEY(24'd10), .HIGH_KEY(25'd10)) u_empty (
    .clock(clock), .reset(reset), .start(e_start),
    .core_done(e_zero), .core_found(e_zero),
    .core_start(e_core_start), .core_key(e_core_key), .core_halt(e_core_halt),
    .busy(e_busy), .pass(e_pass), .fail(e_fail),
    .found_key(e_found_key), .found_core(e_found_core), .keys_tried(e_keys_tried)
  );

  // Core model and dispatch scoreboard, evaluated mid-cycle.
  always @(negedge clock) begin
    if (sb_clr) begin
      for (int j = 0; j < 16; j++) disp_cnt[j] = 0;
      n_starts = 0;
      e_starts = 0;
    end
    for (int i = 0; i < NC; i++) begin
      m_done[i]  = 1'b0;
      m_found[i] = 1'b0;
      if (reset || core_halt) begin
        cnt[i] = 0;
      end else begin
        if (cnt[i] != 0) begin
          cnt[i] = cnt[i] - 1;
          if (cnt[i] == 0) begin
            m_done[i]  = 1'b1;
            m_found[i] = match_en && (cur_key[i] == match_key);
          end
        end
        if (core_start[i]) begin
          cnt[i]     = 5;
          cur_key[i] = core_key[i*KW +: KW];
          n_starts   = n_starts + 1;
          kidx       = int'(core_key[i*KW +: KW]);
          if (kidx < 16) disp_cnt[kidx] = disp_cnt[kidx] + 1;
        end
      end
    end
    if (|e_core_start) e_starts = e_starts + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; sb_clr = 1'b1; start = 1'b0; auto_en = 1'b0;
    match_en = 1'b0; man_done = '0; man_found = '0;
    tick(); tick();
    reset = 1'b0; sb_clr = 1'b0;
  endtask

  function automatic int sb_bad();
    int b = 0;
    for (int j = 0; j < 16; j++) if (disp_cnt[j] != 1) b++;
    return b;
  endfunction

  task automatic wait_end(output int k, input int k0);
    k = k0;
    while (!(pass || fail) && k < 200) begin
      tick();
      k++;
    end
  endtask

  initial begin
    int k;
    int snap;
    int n;
    for (int i = 0; i < NC; i++) begin cnt[i] = 0; cur_key[i] = '0; end
    for (int j = 0; j < 16; j++) disp_cnt[j] = 0;

    // Reset state of both instances.
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_pass", pass, 0);
    check("rst_fail", fail, 0);
    check("rst_halt", core_halt, 0);
    check("rst_start", core_start, 0);
    check("rst_fkey", found_key, 0);
    check("rst_fcore", found_core, 0);
    check("rst_ktried", keys_tried, 0);
    check("rst_key", core_key, 0);
    check("rst_e_key", e_core_key, {4{24'd10}});

    // Empty range: immediate FAIL, no dispatch, start ignored afterwards.
    e_start = 1'b1; tick(); e_start = 1'b0;
    check("empty_busy", e_busy, 1);
    check("empty_nostart", e_core_start, 0);
    tick();
    check("empty_fail", e_fail, 1);
    check("empty_halt", e_core_halt, 1);
    check("empty_busy_off", e_busy, 0);
    check("empty_pass", e_pass, 0);
    e_start = 1'b1; tick(); e_start = 1'b0; tick();
    check("empty_restart_fail", e_fail, 1);
    check("empty_restart_busy", e_busy, 0);
    check("empty_starts", e_starts, 0);

    // Full range, no match.
    do_reset();
    auto_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    check("t1_start0", core_start, 4'b0001);
    check("t1_key0", core_key[0 +: KW], 0);
    check("t1_busy", busy, 1);
    for (int c = 1; c < NC; c++) begin
      tick();
      check($sformatf("t1_start%0d", c), core_start, 4'b0001 << c);
      check($sformatf("t1_key%0d", c), core_key[c*KW +: KW], c);
    end
    wait_end(k, 3);
    check("t1_fail", fail, 1);
    check("t1_pass", pass, 0);
    check("t1_cycles", k, 31);
    check("t1_nstarts", n_starts, 16);
    check("t1_sb", sb_bad(), 0);
`ifdef SCHED_PERF_CNT_EN
    check("t1_ktried", keys_tried, 16);
`else
    check("t1_ktried", keys_tried, 0);
`endif

    // Core 2 finds key 6.
    do_reset();
    auto_en = 1'b1; match_en = 1'b1; match_key = 24'd6;
    start = 1'b1; tick(); start = 1'b0;
    wait_end(k, 0);
    check("t2_pass", pass, 1);
    check("t2_cycles", k, 15);
    check("t2_fkey", found_key, 6);
    check("t2_fcore", found_core, 2);
    check("t2_halt", core_halt, 1);
    check("t2_busy", busy, 0);
    check("t2_fail", fail, 0);
    check("t2_nostart", core_start, 0);
    check("t2_nstarts", n_starts, 9);
`ifdef SCHED_PERF_CNT_EN
    check("t2_ktried", keys_tried, 7);
`endif
    snap = n_starts;
    repeat (10) tick();
    check("t2_quiet", n_starts - snap, 0);
    check("t2_pass_hold", pass, 1);

    // Simultaneous found on cores 1 and 3.
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    check("t3_start3", core_start, 4'b1000);
    tick();
    check("t3_full", core_start, 0);
    man_done = 4'b1010; man_found = 4'b1010;
    tick();
    man_done = '0; man_found = '0;
    check("t3_pass", pass, 1);
    check("t3_fcore", found_core, 1);
    check("t3_fkey", found_key, 1);
`ifdef SCHED_PERF_CNT_EN
    check("t3_ktried", keys_tried, 2);
`endif

    // Done on core 0 while core 1 is being dispatched.
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    check("t4_start0", core_start, 4'b0001);
    tick();
    check("t4_start1", core_start, 4'b0010);
    man_done = 4'b0001;
    tick();
    man_done = '0; auto_en = 1'b1;
    check("t4_no_redisp", core_start, 4'b0100);
    tick();
    check("t4_redisp", core_start, 4'b0001);
    check("t4_redisp_key", core_key[0 +: KW], 3);
    wait_end(k, 3);
    check("t4_fail", fail, 1);
    check("t4_nstarts", n_starts, 16);
    check("t4_sb", sb_bad(), 0);
`ifdef SCHED_PERF_CNT_EN
    check("t4_ktried", keys_tried, 16);
`endif

    // Reset after seven dispatches, then a fresh run.
    do_reset();
    auto_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    n = 1;
    k = 0;
    while (n < 7 && k < 50) begin
      tick();
      k++;
      if (|core_start) n++;
    end
    check("t6_seven", n, 7);
    reset = 1'b1;
    tick();
    check("t6_busy", busy, 0);
    check("t6_start", core_start, 0);
    check("t6_halt", core_halt, 0);
    check("t6_pass", pass, 0);
    check("t6_fail", fail, 0);
    check("t6_key", core_key, 0);
    check("t6_ktried", keys_tried, 0);
    do_reset();
    auto_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    check("t6_restart", core_start, 4'b0001);
    check("t6_restart_key", core_key[0 +: KW], 0);
    check("t6_restart_kt", keys_tried, 0);
    wait_end(k, 0);
    check("t6_fail_end", fail, 1);
    check("t6_nstarts", n_starts, 16);
    check("t6_sb", sb_bad(), 0);
`ifdef SCHED_PERF_CNT_EN
    check("t6_ktried_end", keys_tried, 16);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
